// File: rtl/pattern_shifter_if.sv
// Load handshake and serial output bundle for pattern_shifter.
// The master is the controller that loads patterns; the slave is the shifter itself.
interface pattern_shifter_if #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned LEN_W = 4
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] pattern;
    logic [LEN_W-1:0] length;
    logic             repeat_en;
    logic             abort;
    logic             serial_out;
    logic             bit_tick;
    logic             busy;
    logic             done;

    modport master (
        output load_valid, pattern, length, repeat_en, abort,
        input  load_ready, serial_out, bit_tick, busy, done
    );

    modport slave (
        input  load_valid, pattern, length, repeat_en, abort,
        output load_ready, serial_out, bit_tick, busy, done
    );
endinterface

// File: rtl/pattern_shifter.sv
// Serial pattern player: shifts a loaded pattern out MSB-first, one bit per
// TICK_DIV clocks, with one-shot/repeat modes, abort and busy/done status.
module pattern_shifter #(
    parameter int unsigned WIDTH    = 12,
    parameter int unsigned TICK_DIV = 25000000,
    parameter int unsigned LEN_W    = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    pattern_shifter_if.slave  bus
);
    localparam int unsigned      DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] saved;
    logic [DIV_W-1:0] div_cnt;
    logic [LEN_W-1:0] bit_cnt;
    logic [LEN_W-1:0] len_q;
    logic             serial_q;
    logic             tick_q;
    logic             busy_q;
    logic             done_q;
    logic [LEN_W-1:0] len_clamped;

    // Zero or over-long lengths mean "play the whole register"
    assign len_clamped = (bus.length == '0 || bus.length > FULL_LEN) ? FULL_LEN : bus.length;

    assign bus.load_ready = (state == IDLE);
    assign bus.serial_out = serial_q;
    assign bus.bit_tick   = tick_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            shreg    <= '0;
            saved    <= '0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            len_q    <= '0;
            serial_q <= 1'b0;
            tick_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    // Abort blocks a load presented on the same edge
                    if (bus.load_valid && !bus.abort) begin
                        state    <= SHIFT;
                        shreg    <= bus.pattern;
                        saved    <= bus.pattern;
                        len_q    <= len_clamped;
                        bit_cnt  <= '0;
                        div_cnt  <= DIV_LAST;
                        serial_q <= bus.pattern[WIDTH-1];
                        busy_q   <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (bus.abort) begin
                        state    <= IDLE;
                        shreg    <= '0;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        serial_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end else if (div_cnt == '0) begin
                        div_cnt <= DIV_LAST;
                        tick_q  <= 1'b1;
                        if (bit_cnt == len_q - LEN_W'(1)) begin
                            if (bus.repeat_en) begin
                                shreg    <= saved;
                                bit_cnt  <= '0;
                                serial_q <= saved[WIDTH-1];
                            end else begin
                                state    <= IDLE;
                                shreg    <= '0;
                                bit_cnt  <= '0;
                                serial_q <= 1'b0;
                                busy_q   <= 1'b0;
                                done_q   <= 1'b1;
                            end
                        end else begin
                            shreg    <= {shreg[WIDTH-2:0], 1'b0};
                            serial_q <= shreg[WIDTH-2];
                            bit_cnt  <= bit_cnt + LEN_W'(1);
                        end
                    end else begin
                        div_cnt <= div_cnt - DIV_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/pattern_shifter.md
Name: pattern_shifter

Overview:
- Parametrised serial pattern player. Accepts a WIDTH-bit pattern and a length over a valid/ready load handshake, then shifts the pattern out MSB-first at one bit per TICK_DIV clock cycles.
- Bit timing comes from an internal divider, so no external slowed clock is needed.
- Supports one-shot and repeat modes, abort, and busy/done status.
- Sits between control FSMs and LED/buzzer outputs that signal sensor alarm codes.

Parameters:
- WIDTH, 12, pattern register width in bits (≥2).
- TICK_DIV, 25000000, clock cycles per output bit (≥1); divider counter width is clog2(TICK_DIV), minimum 1.
- LEN_W, 4, width of the length input; must satisfy 2^LEN_W > WIDTH.

Ports:
- clock  in  1  system clock; all flops rise-edge.
- reset_n  in  1  asynchronous active-low reset.
- load_valid  in  1  request to load pattern/length.
- load_ready  out  1  high only in IDLE.
- pattern  in  WIDTH  bits to send; bit WIDTH-1 is sent first.
- length  in  LEN_W  number of bits to send; 0 or values >WIDTH are clamped to WIDTH.
- repeat_en  in  1  sampled at each end-of-pattern; 1 = restart from the captured pattern.
- abort  in  1  synchronous stop.
- serial_out  out  1  current bit.
- bit_tick  out  1  one-cycle pulse at every bit boundary.
- busy  out  1  high in SHIFT.
- done  out  1  one-cycle pulse when a one-shot pattern completes.

Behaviour:
- States: IDLE, SHIFT.
- Reset (async, immediate): state=IDLE; shift register, saved pattern, divider count, bit count, serial_out, bit_tick, busy, done all 0; load_ready=1 (decoded from state).
- IDLE:
  - serial_out=0, load_ready=1.
  - On an edge with load_valid=1: capture pattern into the shift register and into a saved copy; capture clamped length into len_q; bit count=0; divider=TICK_DIV-1; go to SHIFT.
  - After acceptance at edge k, serial_out = pattern[WIDTH-1] from cycle k+1.
- SHIFT:
  - busy=1, load_ready=0; load_valid is ignored.
  - serial_out = shift register MSB.
  - Divider decrements each cycle. When it reaches 0 (tick), the next edge reloads TICK_DIV-1 and asserts bit_tick for that cycle.
  - Each bit is held exactly TICK_DIV cycles. TICK_DIV=1 means a tick every cycle.
- On tick, when bit count < len_q-1: shift left by 1 (LSB fill 0), bit count+1.
- On tick, when bit count == len_q-1 (last bit):
  - repeat_en=1: reload the shift register from the saved copy, bit count=0, stay in SHIFT. No done pulse; output is gapless.
  - repeat_en=0: go to IDLE, serial_out=0, done=1 for exactly one cycle.
- abort=1 in SHIFT: next edge goes to IDLE, clears the shift register, counters and serial_out. No done pulse. Abort wins over a simultaneous tick, last-bit completion or repeat.
- abort in IDLE has no effect. abort together with load_valid in IDLE: abort wins and the load is not accepted.
- Length clamp: len_q = (length==0 || length>WIDTH) ? WIDTH : length.
- Counter wrap: the divider never underflows (reload at 0); bit count never exceeds len_q-1.
- Changing pattern/length inputs during SHIFT has no effect; only captured values are used.
- repeat_en is read only at the last-bit tick. Deasserting it mid-pattern ends the run after the current pattern completes.
- Reset asserted mid-operation: immediate return to reset values; no done pulse.
- bit_tick and done are registered outputs. bit_tick pulses at every tick, including the final one.

Test Plan (TICK_DIV=4, WIDTH=12, LEN_W=4):
- Reset, then load pattern=12'b1010_0000_0000, length=4, repeat_en=0 → serial_out 1,0,1,0, each held 4 cycles from the cycle after acceptance; bit_tick pulses 4 times; done pulses once, 16 cycles after acceptance; busy high those 16 cycles; serial_out=0 afterwards.
- length=0 with pattern=12'hFFF → 48 cycles of serial_out=1, then done. length=13 gives the same result (clamp).
- pattern=12'b1100_0000_0000, length=3, repeat_en=1 → repeating 1,1,0,1,1,0… with no gap and no done. Drop repeat_en mid-pattern → current pattern finishes, then done pulses once.
- Assert abort during bit 2 → IDLE next edge, serial_out=0, busy=0, no done, load_ready=1.
- load_valid held high during SHIFT with a different pattern → ignored. After done, the next load is accepted on the first IDLE edge with load_valid=1.
- Drop reset_n asynchronously mid-bit → outputs 0 immediately (serial_out, busy, done, bit_tick), load_ready=1. After release, a new load plays normally.
